// File: rtl/pcm_rom_arb_pkg.sv
// ---------------------------------------------------------------
// pcm_rom_arb_pkg : shared types and defaults for the ROM arbiter
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

package pcm_rom_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int N_DEF        = 4;
  localparam int AW_DEF       = 18;
  localparam int WAIT_MIN_DEF = 2;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pcm_rom_arb_rr.sv
// ---------------------------------------------------------------
// pcm_rom_arb_rr : cyclic pick of the next pending requester
// Option macro: PCM_ROM_ARB_PRIO_EN (requester 0 always wins)
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module pcm_rom_arb_rr #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  pending,
  input  logic [GW-1:0] last_grant,
  output logic [GW-1:0] grant,
  output logic          any
);

  logic [N-1:0] mask;
  logic         found;
  int           idx;

  always_comb begin
    mask  = pending;
    grant = '0;
    found = 1'b0;
    idx   = 0;
`ifdef PCM_ROM_ARB_PRIO_EN
    // Requester 0 is handled outside the rotation.
    mask[0] = 1'b0;
`endif
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!found && mask[idx]) begin
        grant = GW'(idx);
        found = 1'b1;
      end
    end
`ifdef PCM_ROM_ARB_PRIO_EN
    if (pending[0]) begin
      grant = '0;
    end
`endif
    any = |pending;
  end

endmodule

`default_nettype wire

// File: rtl/pcm_rom_arb.sv
// ---------------------------------------------------------------
// pcm_rom_arb : N-requester byte cache slots sharing one slow ROM
// Option macro: PCM_ROM_ARB_PRIO_EN (see pcm_rom_arb_rr)
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module pcm_rom_arb
  import pcm_rom_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int AW       = AW_DEF,
  parameter int WAIT_MIN = WAIT_MIN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_cs,
  input  logic [N*AW-1:0] req_addr,
  output logic [N*8-1:0]  req_data,
  output logic [N-1:0]    req_ok,
  output logic [AW-1:0]   rom_addr,
  output logic            rom_cs,
  input  logic [7:0]      rom_data,
  input  logic            rom_ok
);

  localparam int GW = idx_w(N);
  localparam int CW = (WAIT_MIN < 1) ? 1 : $clog2(WAIT_MIN + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [GW-1:0] last_grant;

  logic [N-1:0]  valid;
  logic [AW-1:0] tag  [N];
  logic [7:0]    data [N];
  logic [AW-1:0] addr_arr [N];

  logic [N-1:0]  pending;
  logic [GW-1:0] gnt;
  logic          any;
  logic          abort;
  logic          done;

  generate
    for (genvar i = 0; i < N; i++) begin : g_slot
      assign addr_arr[i]        = req_addr[i*AW +: AW];
      assign req_ok[i]          = req_cs[i] & valid[i] & (addr_arr[i] == tag[i]);
      assign req_data[i*8 +: 8] = data[i];
    end
  endgenerate

  assign pending = req_cs & ~req_ok;

  pcm_rom_arb_rr #(
    .N  (N),
    .GW (GW)
  ) u_rr (
    .pending    (pending),
    .last_grant (last_grant),
    .grant      (gnt),
    .any        (any)
  );

  // During WAIT last_grant names the requester being served.
  assign abort = !req_cs[last_grant] || (addr_arr[last_grant] != rom_addr);
  assign done  = rom_ok && (cnt == CW'(WAIT_MIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rom_cs     <= 1'b0;
      rom_addr   <= '0;
      cnt        <= '0;
      last_grant <= GW'(N - 1);
      valid      <= '0;
      for (int i = 0; i < N; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            rom_addr   <= addr_arr[gnt];
            rom_cs     <= 1'b1;
            cnt        <= '0;
            last_grant <= gnt;
            state      <= WAIT;
          end else begin
            rom_cs <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt != CW'(WAIT_MIN)) begin
            cnt <= cnt + 1'b1;
          end
          // A requester that moved away invalidates its slot, even if data arrives now.
          if (abort) begin
            valid[last_grant] <= 1'b0;
            rom_cs            <= 1'b0;
            state             <= IDLE;
          end else if (done) begin
            data[last_grant]  <= rom_data;
            tag[last_grant]   <= rom_addr;
            valid[last_grant] <= 1'b1;
            rom_cs            <= 1'b0;
            state             <= IDLE;
          end
        end
        default: begin
          rom_cs <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pcm_rom_arb.sv
// ---------------------------------------------------------------
// tb_pcm_rom_arb : scoreboard bench for pcm_rom_arb (N=4, AW=18, WAIT_MIN=2)
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_pcm_rom_arb;

  localparam int N  = 4;
  localparam int AW = 18;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_cs;
  logic [N*AW-1:0] req_addr;
  logic [N*8-1:0]  req_data;
  logic [N-1:0]    req_ok;
  logic [AW-1:0]   rom_addr;
  logic            rom_cs;
  logic [7:0]      rom_data;
  logic            rom_ok;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [AW-1:0] exp_q[$];
  int            gcyc[$];
  logic          prev_cs = 1'b0;

  pcm_rom_arb #(.N(N), .AW(AW), .WAIT_MIN(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_cs   (req_cs),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ok   (req_ok),
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_data (rom_data),
    .rom_ok   (rom_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ROM model: content is a fixed function of the address.
  function automatic logic [7:0] rom_fn(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction
  assign rom_data = rom_fn(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    req_cs = '0;
    tick(2);
    rst    = 1'b0;
  endtask

  task automatic sb_drained(input string tag);
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Every new access (rom_cs rising) is matched against the expected grant order.
  always @(negedge clk) begin
    if (!rst && rom_cs && !prev_cs) begin
      gcyc.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_grant", {14'h0, rom_addr}, 32'hFFFF_FFFF);
      else                   check("grant_addr", {14'h0, rom_addr}, {14'h0, exp_q.pop_front()});
    end
    prev_cs = rom_cs;
  end

  initial begin
    rst      = 1'b1;
    req_cs   = '0;
    req_addr = '0;
    rom_ok   = 1'b0;

    // Reset state
    do_reset();
    check("reset_rom_cs", rom_cs, 0);
    check("reset_rom_addr", rom_addr, 0);
    check("reset_req_ok", req_ok, 0);

    // Single access, latency T+4
    rom_ok = 1'b1;
    set_addr(0, 18'h00100);
    req_cs = 4'b0001;
    exp_q.push_back(18'h00100);
    tick(1);
    check("s1_rom_addr", rom_addr, 18'h00100);
    check("s1_rom_cs", rom_cs, 1);
    tick(2);
    check("s1_ok_early", req_ok[0], 0);
    tick(1);
    check("s1_ok", req_ok[0], 1);
    check("s1_data", req_data[7:0], 8'h5A);
    tick(8);
    check("s1_ok_held", req_ok[0], 1);
    sb_drained("s1_sb_empty");

    // All four pending from reset: round-robin 0,1,2,3
    do_reset();
    set_addr(0, 18'h01011);
    set_addr(1, 18'h02022);
    set_addr(2, 18'h03033);
    set_addr(3, 18'h04044);
`ifndef PCM_ROM_ARB_PRIO_EN
    gcyc.delete();
    req_cs = 4'b1111;
    for (int i = 0; i < N; i++) exp_q.push_back(req_addr[i*AW +: AW]);
    tick(20);
    check("s2_ngrants", gcyc.size(), 4);
    for (int i = 0; i + 1 < gcyc.size(); i++) check("s2_gap", gcyc[i+1] - gcyc[i], 4);
    check("s2_ok_all", req_ok, 4'hF);
    for (int i = 0; i < N; i++) check("s2_data", req_data[i*8 +: 8], rom_fn(req_addr[i*AW +: AW]));
    sb_drained("s2_sb_empty");
`endif

    // Requester 0 keeps re-requesting while 1..3 wait
    do_reset();
    set_addr(0, 18'h00A00);
    req_cs = 4'b1111;
`ifdef PCM_ROM_ARB_PRIO_EN
    exp_q.push_back(18'h00A00); exp_q.push_back(18'h02022);
    exp_q.push_back(18'h00B0B); exp_q.push_back(18'h03033);
    exp_q.push_back(18'h00C0C); exp_q.push_back(18'h04044);
`else
    exp_q.push_back(18'h00A00); exp_q.push_back(18'h02022);
    exp_q.push_back(18'h03033); exp_q.push_back(18'h04044);
    exp_q.push_back(18'h00C0C);
`endif
    tick(5);
    set_addr(0, 18'h00B0B);
    tick(8);
    set_addr(0, 18'h00C0C);
    tick(20);
    check("s3_ok_all", req_ok, 4'hF);
    check("s3_data0", req_data[7:0], rom_fn(18'h00C0C));
    sb_drained("s3_sb_empty");

    // rom_ok pulsed while cnt==1 is ignored; accepted at cnt==2
    do_reset();
    rom_ok = 1'b0;
    set_addr(0, 18'h00321);
    req_cs = 4'b0001;
    exp_q.push_back(18'h00321);
    tick(2);
    rom_ok = 1'b1;
    tick(1);
    rom_ok = 1'b0;
    check("s4_still_wait", rom_cs, 1);
    check("s4_ok_low", req_ok[0], 0);
    tick(3);
    check("s4_hold_wait", rom_cs, 1);
    rom_ok = 1'b1;
    tick(1);
    check("s4_ok", req_ok[0], 1);
    check("s4_data", req_data[7:0], rom_fn(18'h00321));
    check("s4_cs_off", rom_cs, 0);
    sb_drained("s4_sb_empty");

    // Granted requester moves its address mid-access: abort, then re-grant
    do_reset();
    rom_ok = 1'b1;
    set_addr(0, 18'h00100);
    req_cs = 4'b0001;
    exp_q.push_back(18'h00100);
    exp_q.push_back(18'h00200);
    tick(1);
    set_addr(0, 18'h00200);
    tick(1);
    check("s5_abort_cs", rom_cs, 0);
    check("s5_abort_ok", req_ok[0], 0);
    tick(1);
    check("s5_regrant", rom_addr, 18'h00200);
    tick(3);
    check("s5_ok", req_ok[0], 1);
    check("s5_data", req_data[7:0], rom_fn(18'h00200));
    sb_drained("s5_sb_empty");

    // Reset in WAIT discards the access; requester 0 is served first afterwards
    do_reset();
    rom_ok = 1'b0;
    set_addr(0, 18'h00111);
    set_addr(1, 18'h00222);
    req_cs = 4'b0011;
    exp_q.push_back(18'h00111);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("s6_rst_cs", rom_cs, 0);
    check("s6_rst_ok", req_ok, 0);
    check("s6_rst_addr", rom_addr, 0);
    sb_drained("s6_sb_pre");
    exp_q.push_back(18'h00111);
    exp_q.push_back(18'h00222);
    rom_ok = 1'b1;
    rst    = 1'b0;
    tick(1);
    check("s6_first_grant", rom_addr, 18'h00111);
    tick(10);
    check("s6_ok", req_ok, 4'b0011);
    check("s6_data1", req_data[15:8], rom_fn(18'h00222));
    sb_drained("s6_sb_empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pcm_rom_arb.md
PCM_ROM_ARB -- requirements
Module: pcm_rom_arb

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-002 Parameter N SHALL default to 4 and sets the number of requesters.
REQ-003 Parameter AW SHALL default to 18 and sets the address width.
REQ-004 Parameter WAIT_MIN SHALL default to 2 and sets the number of WAIT cycles in which rom_ok is ignored after an address is issued.
REQ-005 Port clk SHALL be an input, 1 bit wide: the system clock.
REQ-006 Port rst SHALL be an input, 1 bit wide: synchronous active-high reset.
REQ-007 Port req_cs SHALL be an input, N bits wide: per-requester access enable.
REQ-008 Port req_addr SHALL be an input, N*AW bits wide: requester i uses bits [i*AW +: AW].
REQ-009 Port req_data SHALL be an output, N*8 bits wide: latched byte per requester.
REQ-010 Port req_ok SHALL be an output, N bits wide: req_data[i] is valid for the current req_addr[i].
REQ-011 Port rom_addr SHALL be an output, AW bits wide: the shared ROM address, registered.
REQ-012 Port rom_cs SHALL be an output, 1 bit wide: ROM access strobe, registered.
REQ-013 Port rom_data SHALL be an input, 8 bits wide: ROM read data.
REQ-014 Port rom_ok SHALL be an input, 1 bit wide: rom_data is valid for rom_addr.

Function
REQ-015 Each requester SHALL own a one-entry slot made of valid[i], tag[i] (AW bits) and data[i] (8 bits).
REQ-016 req_ok[i] SHALL equal req_cs[i] & valid[i] & (req_addr[i]==tag[i]), computed combinationally from registered state; req_data[i] SHALL equal data[i].
REQ-017 Requester i is pending when req_cs[i]=1 and not req_ok[i].
REQ-018 The FSM SHALL have the states IDLE and WAIT.
REQ-019 In IDLE with at least one requester pending, the block SHALL grant the first pending index searched cyclically from last_grant+1, register rom_addr=req_addr[g] and rom_cs=1, clear cnt, store g in last_grant, and move to WAIT.
REQ-020 In IDLE with no requester pending, rom_cs SHALL be 0 and rom_addr SHALL hold its value.
REQ-021 In WAIT, cnt SHALL increment each cycle and saturate at WAIT_MIN.
REQ-022 In WAIT, rom_ok SHALL be accepted only in a cycle where cnt==WAIT_MIN, at which point the block SHALL set data[g]=rom_data, tag[g]=rom_addr and valid[g]=1, set rom_cs=0, and return to IDLE.
REQ-023 In WAIT, if req_cs[g]=0 or req_addr[g]!=rom_addr, the block SHALL abort: valid[g]=0, rom_cs=0, return to IDLE, data unchanged; abort SHALL take priority over a simultaneous rom_ok.
REQ-024 Latency: with rom_ok held high, pending first seen in IDLE in cycle T SHALL give req_ok high in cycle T+WAIT_MIN+2.
REQ-025 After each access an IDLE cycle SHALL follow, so back-to-back grants are at least WAIT_MIN+2 cycles apart.
REQ-026 An address change on a non-granted requester SHALL only drop its req_ok and make it pending; it SHALL NOT disturb the access in flight.
REQ-027 rom_ok that stays low SHALL hold WAIT indefinitely; no timeout is provided.

Reset
REQ-028 On rst the block SHALL force state=IDLE, rom_cs=0, rom_addr=0, cnt=0, last_grant=N-1, and every valid, tag and data to 0, so every req_ok is 0.
REQ-029 rst asserted during WAIT SHALL discard the access with no slot update.

Configuration
REQ-030 With PCM_ROM_ARB_PRIO_EN defined, requester 0 SHALL win whenever it is pending; the other requesters SHALL rotate round-robin among themselves.
REQ-031 Without PCM_ROM_ARB_PRIO_EN, pure round-robin over all N requesters SHALL apply.

Structure
REQ-032 Package pcm_rom_arb_pkg SHALL hold the state enum (IDLE, WAIT) and the default constants for N, AW and WAIT_MIN.
REQ-033 Sub-module pcm_rom_arb_rr SHALL implement the combinational cyclic pick: pending mask and last_grant in, grant index and any-pending flag out, with the priority option applied inside it.

Verification
REQ-034 The bench SHALL cover: req_cs=0001, addr0=0x00100, rom_ok=1 constant, rom_data=0x5A -> rom_addr=0x00100 one cycle later, req_ok[0]=1 and req_data[0]=0x5A at T+4, one access only.
REQ-035 The bench SHALL cover: all four requesters pending from reset -> grants in order 0,1,2,3, each 4 cycles apart, without PCM_ROM_ARB_PRIO_EN.
REQ-036 The bench SHALL cover: the PCM_ROM_ARB_PRIO_EN build with requester 0 re-requesting a new address after each grant and requesters 1-3 pending -> order 0,1,0,2,0,3.
REQ-037 The bench SHALL cover: rom_ok pulsed at cnt=1 only -> ignored, FSM stays in WAIT; rom_ok high at cnt=2 -> data latched.
REQ-038 The bench SHALL cover: the granted requester changes addr 0x00100->0x00200 in WAIT while rom_ok=1 -> abort, valid=0, re-grant of 0x00200 on the next IDLE pass.
REQ-039 The bench SHALL cover: rst pulsed in WAIT -> rom_cs=0 and all req_ok=0 next cycle; a request after reset is served by requester 0 first.
